// File: rtl/dm_ctrl_if.sv
// Request/response bus between the MEM stage (master) and dm_ctrl (slave).
// One outstanding request at a time; completion is signalled by a done pulse.
interface dm_ctrl_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              ready;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  ready, rdata, done, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output ready, rdata, done, err
    );
endinterface

// File: rtl/dm_ctrl.sv
// Load/store controller for the word-only dm_4k data memory: byte/half/word
// loads with lane select and extension, sub-word stores by read-modify-write.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready, waiting for a request
// ST_LOAD   | memory read of latched word, extract and extend lane
// ST_RMW_RD | read old word, merge new byte/half into merge register
// ST_WRITE  | dm_we high for one cycle, merge register on dm_din
// ST_RESP   | done pulse (err valid), back to idle
module dm_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_ctrl_if.slave    bus,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_din_o,
    output logic        dm_we_o,
    input  logic [31:0] dm_dout_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic        err_q, err_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] lane_ext;
    logic [31:0] merged;

    always_comb begin
        case (bus.size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.addr[0];
            SZ_WORD: misaligned = |bus.addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane extraction and extension of the word currently on dm_dout.
    always_comb begin
        ld_byte  = dm_dout_i[{off_q, 3'b000} +: 8];
        ld_half  = off_q[1] ? dm_dout_i[31:16] : dm_dout_i[15:0];
        lane_ext = dm_dout_i;
        case (size_q)
            SZ_BYTE: lane_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: lane_ext = {{16{sext_q & ld_half[15]}}, ld_half};
            default: lane_ext = dm_dout_i;
        endcase
    end

    // Old word with the addressed lane replaced; store data waits in merge_q.
    always_comb begin
        merged = dm_dout_i;
        case (size_q)
            SZ_BYTE: merged[{off_q, 3'b000} +: 8] = merge_q[7:0];
            SZ_HALF: begin
                if (off_q[1]) begin
                    merged[31:16] = merge_q[15:0];
                end else begin
                    merged[15:0] = merge_q[15:0];
                end
            end
            default: merged = merge_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        size_d    = size_q;
        sext_d    = sext_q;
        err_d     = err_q;
        dm_addr_d = dm_addr_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    off_d     = bus.addr[1:0];
                    size_d    = bus.size;
                    sext_d    = bus.sign_ext;
                    dm_addr_d = 32'(bus.addr[ADDR_W-1:2]);
                    merge_d   = bus.wdata;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (!bus.we) begin
                        state_d = ST_LOAD;
                    end else if (bus.size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                rdata_d = lane_ext;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                merge_d = merged;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            err_q     <= 1'b0;
            dm_addr_q <= 32'h0;
            merge_q   <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            off_q     <= off_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            err_q     <= err_d;
            dm_addr_q <= dm_addr_d;
            merge_q   <= merge_d;
            rdata_q   <= rdata_d;
        end
    end

    // Strobes decode straight from state so reset kills an in-flight write.
    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = (state_q == ST_RESP);
    assign dm_we_o   = (state_q == ST_WRITE);
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign dm_addr_o = dm_addr_q;
    assign dm_din_o  = merge_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a small behavioural dm_4k (combinational
// read, write on rising clk) and hand-computed expectations.
module tb_dm_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_ctrl_if #(.ADDR_W(32)) bus ();

    logic [31:0] dm_addr, dm_din, dm_dout;
    logic        dm_we;

    dm_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dm_addr_o (dm_addr),
        .dm_din_o  (dm_din),
        .dm_we_o   (dm_we),
        .dm_dout_i (dm_dout)
    );

    logic [31:0] mem [0:15];
    assign dm_dout = mem[dm_addr[3:0]];

    int we_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [31:0] last_we_addr = 32'h0;

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr[3:0]] <= dm_din;
            we_cnt            <= we_cnt + 1;
            last_we_addr      <= dm_addr;
        end
        if (bus.req && bus.ready) acc_cnt <= acc_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   32'(bus.ready), 32'd1);
        chk({tag, "_done"},    32'(bus.done),  32'd0);
        chk({tag, "_err"},     32'(bus.err),   32'd0);
        chk({tag, "_dm_we"},   32'(dm_we),     32'd0);
        chk({tag, "_dm_addr"}, dm_addr,        32'h0);
        chk({tag, "_dm_din"},  dm_din,         32'h0);
        chk({tag, "_rdata"},   bus.rdata,      32'h0);
    endtask

    // Issue one request from an idle controller; lat = cycle index of done.
    task automatic xact(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e);
        @(negedge clk);
        chk("ready_before_req", 32'(bus.ready), 32'd1);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = wd;
        @(posedge clk);
        #1 bus.req = 1'b0;
        lat = 99;
        e   = 1'bx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                e   = bus.err;
                break;
            end
        end
    endtask

    int   lat;
    logic e;
    int   w0, a0, d0;
    logic [31:0] tbl [0:8];

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        tbl = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h0};

        #2 chk_reset_outputs("por");
        #20 rst_n = 1'b1;

        // word store then word load @0x0
        w0 = we_cnt;
        xact(1'b1, 2'b10, 1'b0, 32'h0, 32'hAAAA_AAAA, lat, e);
        chk("wst_lat", 32'(lat), 32'd2);
        chk("wst_err", 32'(e), 32'd0);
        chk("wst_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("wst_we_addr", last_we_addr, 32'h0);
        chk("wst_mem", mem[0], 32'hAAAA_AAAA);
        xact(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, e);
        chk("wld_lat", 32'(lat), 32'd2);
        chk("wld_rdata", bus.rdata, 32'hAAAA_AAAA);

        xact(1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFF_ABC0, lat, e);
        xact(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_FFFF, lat, e);
        xact(1'b1, 2'b10, 1'b0, 32'hC, 32'h1122_3344, lat, e);
        chk("pre_we_addr", last_we_addr, 32'h3);

        // byte RMW @0x6 and byte loads @0x5
        w0 = we_cnt;
        xact(1'b1, 2'b00, 1'b0, 32'h6, 32'hDEAD_BE5A, lat, e);
        chk("bst_lat", 32'(lat), 32'd3);
        chk("bst_err", 32'(e), 32'd0);
        chk("bst_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("bst_mem", mem[1], 32'hFF5A_ABC0);
        xact(1'b0, 2'b00, 1'b1, 32'h5, 32'h0, lat, e);
        chk("bld_s_lat", 32'(lat), 32'd2);
        chk("bld_s_rdata", bus.rdata, 32'hFFFF_FFAB);
        xact(1'b0, 2'b00, 1'b0, 32'h5, 32'h0, lat, e);
        chk("bld_u_rdata", bus.rdata, 32'h0000_00AB);
        xact(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, lat, e);
        chk("bld_b3_rdata", bus.rdata, 32'hFFFF_FFFF);

        // halfword RMW @0xA and loads
        xact(1'b1, 2'b01, 1'b0, 32'hA, 32'hCAFE_1234, lat, e);
        chk("hst_lat", 32'(lat), 32'd3);
        chk("hst_mem", mem[2], 32'h1234_FFFF);
        xact(1'b0, 2'b01, 1'b1, 32'h8, 32'h0, lat, e);
        chk("hld_lo_rdata", bus.rdata, 32'hFFFF_FFFF);
        xact(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, lat, e);
        chk("hld_lo_u_rdata", bus.rdata, 32'h0000_FFFF);
        xact(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, lat, e);
        chk("hld_hi_rdata", bus.rdata, 32'h0000_1234);
        chk("hld_hi_err", 32'(e), 32'd0);

        // error requests: no write, rdata held
        w0 = we_cnt;
        xact(1'b1, 2'b01, 1'b0, 32'h3, 32'h5555_5555, lat, e);
        chk("err_half_lat", 32'(lat), 32'd1);
        chk("err_half_err", 32'(e), 32'd1);
        xact(1'b0, 2'b10, 1'b1, 32'h2, 32'h0, lat, e);
        chk("err_word_lat", 32'(lat), 32'd1);
        chk("err_word_err", 32'(e), 32'd1);
        xact(1'b1, 2'b11, 1'b0, 32'h0, 32'h5555_5555, lat, e);
        chk("err_rsv_lat", 32'(lat), 32'd1);
        chk("err_rsv_err", 32'(e), 32'd1);
        chk("err_no_we", 32'(we_cnt - w0), 32'd0);
        chk("err_rdata_held", bus.rdata, 32'h0000_1234);
        chk("err_mem0", mem[0], 32'hAAAA_AAAA);
        @(negedge clk);
        chk("err_low_idle", 32'(bus.err), 32'd0);

        // req held high with changing addresses: accepts at steps 0, 3, 6
        a0 = acc_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
            bus.addr = tbl[i];
        end
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        chk("hs_accepts", 32'(acc_cnt - a0), 32'd3);
        chk("hs_dones", 32'(done_cnt - d0), 32'd3);
        chk("hs_rdata", bus.rdata, 32'h1234_FFFF);

        // reset during RMW_RD of byte store @0xC
        w0 = we_cnt;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'hC; bus.wdata = 32'h0000_0077;
        @(posedge clk);
        #1 bus.req = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_mem", mem[3], 32'h1122_3344);
        chk("midrst_no_we", 32'(we_cnt - w0), 32'd0);
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_no_done", 32'(bus.done), 32'd0);
        xact(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, lat, e);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_rdata", bus.rdata, 32'h1122_3344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
